// File: rtl/apb_master_ctrl.sv
// APB initiator: queues host read/write commands and issues each as one SETUP+ACCESS transfer.
// Optional APB_PREADY_EN adds a PREADY input that can stretch ACCESS; without it ACCESS is one cycle.
module apb_master_ctrl #(
    parameter int Amba_Word       = 24,
    parameter int Amba_Addr_Depth = 12,
    parameter int FifoDepth       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [Amba_Addr_Depth-1:0] cmd_addr,
    input  logic [Amba_Word-1:0]       cmd_wdata,
    output logic                       rsp_valid,
    output logic [Amba_Word-1:0]       rsp_rdata,
    output logic                       busy,
    output logic                       cat_result,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [Amba_Addr_Depth-1:0] PADDR,
    output logic [Amba_Word-1:0]       PWDATA,
    input  logic [Amba_Word-1:0]       PRDATA,
`ifdef APB_PREADY_EN
    input  logic                       PREADY,
`endif
    input  logic                       CatRecOut
);

    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW = PtrW + 1;

    typedef struct packed {
        logic                       write;
        logic [Amba_Addr_Depth-1:0] addr;
        logic [Amba_Word-1:0]       wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    cmd_t                       mem_q [FifoDepth];
    logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]            count_q, count_d;
    logic                       full_q;
    logic                       push, pop, empty;

    state_t                     state_q, state_d;
    logic                       xfer_ready, xfer_done;

    logic                       pwrite_q;
    logic [Amba_Addr_Depth-1:0] paddr_q;
    logic [Amba_Word-1:0]       pwdata_q;
    logic                       rsp_valid_q;
    logic [Amba_Word-1:0]       rsp_rdata_q;
    logic                       cat_result_q;

    cmd_t                       head;

    assign empty     = (count_q == '0);
    assign cmd_ready = !full_q;
    assign push      = cmd_valid && !full_q;
    assign head      = mem_q[rd_ptr_q];

`ifdef APB_PREADY_EN
    assign xfer_ready = PREADY;
`else
    assign xfer_ready = 1'b1;
`endif
    assign xfer_done = (state_q == ACCESS) && xfer_ready;

    // Pops happen only from IDLE or from a completing ACCESS, so the head is
    // loaded onto the bus exactly when the next SETUP begins.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (xfer_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == CntW'(FifoDepth));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            cat_result_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cat_result_q <= CatRecOut;
            if (pop) begin
                pwrite_q <= head.write;
                paddr_q  <= head.addr;
                pwdata_q <= head.wdata;
            end
            rsp_valid_q <= xfer_done && !pwrite_q;
            if (xfer_done && !pwrite_q) begin
                rsp_rdata_q <= PRDATA;
            end
        end
    end

    // Select/enable decode straight from the state register so reset clears them at once.
    assign PSEL       = (state_q != IDLE);
    assign PENABLE    = (state_q == ACCESS);
    assign PWRITE     = pwrite_q;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign cat_result = cat_result_q;
    assign busy       = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed self-checking bench for apb_master_ctrl (default parameters).
// Inputs are driven at the falling edge or just after a rising edge; outputs are sampled at the falling edge.
module tb_apb_master_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [23:0] cmd_wdata;
    logic        rsp_valid;
    logic [23:0] rsp_rdata;
    logic        busy;
    logic        cat_result;
    logic        PSEL, PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [23:0] PWDATA;
    logic [23:0] PRDATA;
    logic        CatRecOut;
`ifdef APB_PREADY_EN
    logic        PREADY;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int rsp_cnt = 0;

    apb_master_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .busy       (busy),
        .cat_result (cat_result),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
`ifdef APB_PREADY_EN
        .PREADY     (PREADY),
`endif
        .CatRecOut  (CatRecOut)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) rsp_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One command presented for exactly one rising edge.
    task automatic send(input logic w, input logic [11:0] a, input logic [23:0] d);
        @(negedge clk);
        check("send_rdy", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    initial begin
        int base;
        logic saw_full;
        logic psel_seen;

        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PRDATA    = '0;
        CatRecOut = 1'b0;
`ifdef APB_PREADY_EN
        PREADY    = 1'b1;
`endif

        // Reset state
        #12;
        check("rst_psel",    PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite",  PWRITE, 0);
        check("rst_paddr",   PADDR, 0);
        check("rst_pwdata",  PWDATA, 0);
        check("rst_rspv",    rsp_valid, 0);
        check("rst_rdata",   rsp_rdata, 0);
        check("rst_busy",    busy, 0);
        check("rst_cat",     cat_result, 0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("rst_rdy", cmd_ready, 1);

        // Single write: accepted at edge T
        send(1'b1, 12'h004, 24'h00ABCD);
        step();
        check("w_T_psel", PSEL, 0);
        check("w_T_busy", busy, 1);
        step();
        check("w_T1_psel", PSEL, 1);
        check("w_T1_pen",  PENABLE, 0);
        check("w_T1_addr", PADDR, 12'h004);
        check("w_T1_data", PWDATA, 24'h00ABCD);
        check("w_T1_wr",   PWRITE, 1);
        step();
        check("w_T2_psel", PSEL, 1);
        check("w_T2_pen",  PENABLE, 1);
        check("w_T2_addr", PADDR, 12'h004);
        check("w_T2_data", PWDATA, 24'h00ABCD);
        check("w_T2_wr",   PWRITE, 1);
        step();
        check("w_T3_psel", PSEL, 0);
        check("w_T3_pen",  PENABLE, 0);
        check("w_T3_busy", busy, 0);
        check("w_T3_addr_hold", PADDR, 12'h004);
        @(posedge clk); #1;
        check("w_no_rsp", rsp_cnt, 0);

        // Single read
        PRDATA = 24'h000123;
        send(1'b0, 12'h000, 24'h0);
        step();
        step();
        check("r_T1_psel", PSEL, 1);
        check("r_T1_wr",   PWRITE, 0);
        check("r_T1_addr", PADDR, 12'h000);
        step();
        check("r_T2_pen", PENABLE, 1);
        step();
        check("r_rspv",  rsp_valid, 1);
        check("r_rdata", rsp_rdata, 24'h000123);
        check("r_psel",  PSEL, 0);
        PRDATA = 24'h555555;
        step();
        check("r_rspv_off",  rsp_valid, 0);
        check("r_rdata_hold", rsp_rdata, 24'h000123);
        check("r_busy",      busy, 0);
        @(posedge clk); #1;
        check("r_rsp_cnt", rsp_cnt, 1);

        // Burst of 8 writes pushed as fast as the queue allows
        saw_full = 1'b0;
        fork
            begin : host
                for (int i = 0; i < 8; i++) begin
                    logic acc;
                    logic rdy;
                    acc = 1'b0;
                    @(negedge clk);
                    cmd_valid = 1'b1;
                    cmd_write = 1'b1;
                    cmd_addr  = 12'h100 + 12'(i);
                    cmd_wdata = 24'(i + 1);
                    for (int w = 0; w < 20; w++) begin
                        rdy = cmd_ready;
                        if (!rdy) saw_full = 1'b1;
                        @(posedge clk);
                        if (rdy) begin
                            acc = 1'b1;
                            break;
                        end
                        @(negedge clk);
                    end
                    #1 cmd_valid = 1'b0;
                    check("burst_acc", acc, 1);
                end
            end
            begin : mon
                @(negedge clk);
                for (int w = 0; w < 20 && PSEL !== 1'b1; w++) @(negedge clk);
                for (int k = 0; k < 16; k++) begin
                    check("burst_psel", PSEL, 1);
                    check("burst_pen",  PENABLE, 64'(k % 2));
                    check("burst_addr", PADDR, 64'(12'h100 + 12'(k / 2)));
                    check("burst_data", PWDATA, 64'(k / 2 + 1));
                    @(negedge clk);
                end
                check("burst_end_psel", PSEL, 0);
            end
        join
        check("burst_full_seen", saw_full, 1);
        check("burst_busy", busy, 0);

        // Reset during SETUP with two commands still queued
        PRDATA = 24'h0000AA;
        send(1'b1, 12'h200, 24'h1);
        send(1'b0, 12'h201, 24'h0);
        send(1'b0, 12'h202, 24'h0);
        send(1'b0, 12'h203, 24'h0);
        check("mid_psel",  PSEL, 1);
        check("mid_pen",   PENABLE, 0);
        check("mid_addr",  PADDR, 12'h201);
        base = rsp_cnt;
        #2 rst = 1'b0;
        #1;
        check("arst_psel", PSEL, 0);
        check("arst_pen",  PENABLE, 0);
        check("arst_busy", busy, 0);
        check("arst_rspv", rsp_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_busy", busy, 0);
        check("post_rdy",  cmd_ready, 1);
        psel_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (PSEL !== 1'b0) psel_seen = 1'b1;
        end
        check("post_no_apb", psel_seen, 0);
        @(posedge clk); #1;
        check("post_no_rsp", rsp_cnt, base);

        // cat_result follows CatRecOut one cycle later
        @(negedge clk);
        CatRecOut = 1'b1;
        #1 check("cat_rise_pre", cat_result, 0);
        @(negedge clk);
        check("cat_rise", cat_result, 1);
        CatRecOut = 1'b0;
        #1 check("cat_fall_pre", cat_result, 1);
        @(negedge clk);
        check("cat_fall", cat_result, 0);

`ifdef APB_PREADY_EN
        // Read stretched by PREADY low
        PREADY = 1'b0;
        PRDATA = 24'h00FFFF;
        send(1'b0, 12'h030, 24'h0);
        step();
        step();
        check("rdy_T1_psel", PSEL, 1);
        check("rdy_T1_pen",  PENABLE, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rdy_wait_psel", PSEL, 1);
            check("rdy_wait_pen",  PENABLE, 1);
            check("rdy_wait_addr", PADDR, 12'h030);
            check("rdy_wait_wr",   PWRITE, 0);
            check("rdy_wait_rspv", rsp_valid, 0);
        end
        PREADY = 1'b1;
        step();
        check("rdy_done_psel", PSEL, 0);
        check("rdy_rspv",      rsp_valid, 1);
        check("rdy_rdata",     rsp_rdata, 24'h00FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
